// File: rtl/bistprj_mbist_ctrl.sv
// March C- memory BIST controller: sequences a single-port SRAM through six March elements.
// Define BIST_DIAG_EN to add first-mismatch address/syndrome capture (BIST_FAIL_ADDR/BIST_FAIL_SYND).
module bistprj_mbist_ctrl #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic              MAS_CLK,
   input  logic              MAS_RST,
   input  logic              BIST_START,
   output logic              BIST_BUSY,
   output logic              BIST_DONE,
   output logic              BIST_FAIL,
`ifdef BIST_DIAG_EN
   output logic [ADDR_W-1:0] BIST_FAIL_ADDR,
   output logic [DATA_W-1:0] BIST_FAIL_SYND,
`endif
   output logic              MEM_CE,
   output logic              MEM_WE,
   output logic [ADDR_W-1:0] MEM_ADDR,
   output logic [DATA_W-1:0] MEM_WDATA,
   input  logic [DATA_W-1:0] MEM_RDATA
);

   typedef enum logic [3:0] {IDLE, M0, M1, M2, M3, M4, M5, DRAIN, FIN} state_t;

   localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

   state_t            state, state_n;
   logic [ADDR_W-1:0] addr, addr_n;
   logic              phase, phase_n;
   logic              start_q, start_edge, run_start;
   logic              down, last_op, last_addr;
   logic              ce_n, we_n;
   logic [DATA_W-1:0] wdata_n, exp_n, exp_q;
   logic              cmp_valid, mismatch;
   logic [DATA_W-1:0] cmp_exp;

   assign start_edge = BIST_START & ~start_q;
   assign run_start  = start_edge & ((state == IDLE) | (state == FIN));
   assign mismatch   = cmp_valid & (MEM_RDATA != cmp_exp);

   always_ff @(posedge MAS_CLK) begin
      if (MAS_RST) begin
         state   <= IDLE;
         addr    <= '0;
         phase   <= 1'b0;
         start_q <= 1'b0;
      end else begin
         state   <= state_n;
         addr    <= addr_n;
         phase   <= phase_n;
         start_q <= BIST_START;
      end
   end

   // phase 0 = read, phase 1 = write; M0 and M5 use a single operation per address
   always_comb begin
      state_n   = state;
      addr_n    = addr;
      phase_n   = phase;
      down      = (state == M3) || (state == M4);
      last_op   = (state == M0) || (state == M5) || phase;
      last_addr = down ? (addr == '0) : (addr == ADDR_LAST);
      case (state)
         IDLE, FIN: begin
            if (run_start) begin
               state_n = M0;
               addr_n  = '0;
               phase_n = 1'b0;
            end
         end
         M0, M1, M2, M3, M4, M5: begin
            if (!last_op) begin
               phase_n = 1'b1;
            end else begin
               phase_n = 1'b0;
               if (!last_addr) begin
                  addr_n = down ? addr - ADDR_W'(1) : addr + ADDR_W'(1);
               end else begin
                  addr_n = '0;
                  case (state)
                     M0:      state_n = M1;
                     M1:      state_n = M2;
                     M2:      begin state_n = M3; addr_n = ADDR_LAST; end
                     M3:      begin state_n = M4; addr_n = ADDR_LAST; end
                     M4:      state_n = M5;
                     default: state_n = DRAIN;
                  endcase
               end
            end
         end
         DRAIN:   state_n = FIN;
         default: state_n = IDLE;
      endcase
   end

   // NOTE: access fields are decoded from the *next* state so the registered outputs line up
   // with the state they describe, without an extra cycle of latency.
   always_comb begin
      ce_n    = 1'b0;
      we_n    = 1'b0;
      wdata_n = '0;
      exp_n   = '0;
      case (state_n)
         M0: begin
            ce_n = 1'b1;
            we_n = 1'b1;
         end
         M1, M3: begin
            ce_n    = 1'b1;
            we_n    = phase_n;
            wdata_n = {DATA_W{phase_n}};
         end
         M2, M4: begin
            ce_n  = 1'b1;
            we_n  = phase_n;
            exp_n = '1;
         end
         M5:      ce_n = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge MAS_CLK) begin
      if (MAS_RST) begin
         BIST_BUSY <= 1'b0;
         BIST_DONE <= 1'b0;
         BIST_FAIL <= 1'b0;
         MEM_CE    <= 1'b0;
         MEM_WE    <= 1'b0;
         MEM_ADDR  <= '0;
         MEM_WDATA <= '0;
         exp_q     <= '0;
         cmp_valid <= 1'b0;
         cmp_exp   <= '0;
      end else begin
         BIST_BUSY <= (state_n != IDLE) && (state_n != FIN);
         BIST_DONE <= (state_n == FIN);
         MEM_CE    <= ce_n;
         MEM_WE    <= we_n;
         MEM_ADDR  <= addr_n;
         MEM_WDATA <= wdata_n;
         exp_q     <= exp_n;
         cmp_valid <= MEM_CE & ~MEM_WE;
         cmp_exp   <= exp_q;
         if (run_start)     BIST_FAIL <= 1'b0;
         else if (mismatch) BIST_FAIL <= 1'b1;
      end
   end

`ifdef BIST_DIAG_EN
   logic [ADDR_W-1:0] cmp_addr;

   always_ff @(posedge MAS_CLK) begin
      if (MAS_RST) begin
         cmp_addr       <= '0;
         BIST_FAIL_ADDR <= '0;
         BIST_FAIL_SYND <= '0;
      end else begin
         cmp_addr <= MEM_ADDR;
         if (run_start) begin
            BIST_FAIL_ADDR <= '0;
            BIST_FAIL_SYND <= '0;
         end else if (mismatch && !BIST_FAIL) begin
            BIST_FAIL_ADDR <= cmp_addr;
            BIST_FAIL_SYND <= MEM_RDATA ^ cmp_exp;
         end
      end
   end
`endif

endmodule

// File: tb/tb_bistprj_mbist_ctrl.sv
// Self-checking bench for bistprj_mbist_ctrl: SRAM model with stuck-at faults, a March C-
// access-list reference model checked every cycle, plus directed literal checks.
module tb_bistprj_mbist_ctrl;

   localparam int ADDR_W = 4;
   localparam int DATA_W = 8;
   localparam int N      = 1 << ADDR_W;
   localparam int NACC   = 10 * N;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic              busy, done, fail;
   logic [ADDR_W-1:0] fail_addr;
   logic [DATA_W-1:0] fail_synd;
   logic              ce, we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata, rdata;

   always #5 clk = ~clk;

   bistprj_mbist_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .MAS_CLK        (clk),
      .MAS_RST        (rst),
      .BIST_START     (start),
      .BIST_BUSY      (busy),
      .BIST_DONE      (done),
      .BIST_FAIL      (fail),
`ifdef BIST_DIAG_EN
      .BIST_FAIL_ADDR (fail_addr),
      .BIST_FAIL_SYND (fail_synd),
`endif
      .MEM_CE         (ce),
      .MEM_WE         (we),
      .MEM_ADDR       (addr),
      .MEM_WDATA      (wdata),
      .MEM_RDATA      (rdata)
   );

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // SRAM with per-address stuck-at-0 / stuck-at-1 masks; read data valid one cycle after the read
   logic [DATA_W-1:0] mem [N];
   logic [DATA_W-1:0] sa0 [N];
   logic [DATA_W-1:0] sa1 [N];

   always @(posedge clk) begin
      if (ce && we) mem[addr] <= wdata;
      if (ce && !we) rdata <= (mem[addr] & ~sa0[addr]) | sa1[addr];
      else           rdata <= DATA_W'($urandom);
   end

   // Reference: the full March C- access list, and which reads a given fault set corrupts
   bit                acc_we   [NACC];
   logic [ADDR_W-1:0] acc_addr [NACC];
   logic [DATA_W-1:0] acc_data [NACC];
   bit                rd_bad   [NACC];
   logic [DATA_W-1:0] rd_synd  [NACC];

   task automatic build_tables();
      int i = 0;
      for (int e = 0; e < 6; e++) begin
         for (int k = 0; k < N; k++) begin
            int a = (e == 3 || e == 4) ? N - 1 - k : k;
            if (e != 0) begin
               acc_we[i] = 1'b0; acc_addr[i] = ADDR_W'(a);
               acc_data[i] = (e == 2 || e == 4) ? 8'hFF : 8'h00;
               i++;
            end
            if (e != 5) begin
               acc_we[i] = 1'b1; acc_addr[i] = ADDR_W'(a);
               acc_data[i] = (e == 1 || e == 3) ? 8'hFF : 8'h00;
               i++;
            end
         end
      end
   endtask

   task automatic set_faults();
      for (int i = 0; i < NACC; i++) begin
         logic [DATA_W-1:0] got;
         got = (acc_data[i] & ~sa0[acc_addr[i]]) | sa1[acc_addr[i]];
         rd_bad[i]  = !acc_we[i] && (got != acc_data[i]);
         rd_synd[i] = got ^ acc_data[i];
      end
   endtask

   task automatic clear_faults();
      for (int a = 0; a < N; a++) begin
         sa0[a] = '0;
         sa1[a] = '0;
      end
   endtask

   // Model state: m_t counts cycles since the start edge while a run is active
   bit                m_active = 1'b0, m_done = 1'b0, m_fail = 1'b0, m_prev = 1'b0;
   int                m_t = 0;
   logic [ADDR_W-1:0] m_faddr = '0;
   logic [DATA_W-1:0] m_fsynd = '0;

   task automatic model_step();
      if (rst) begin
         m_active = 1'b0; m_done = 1'b0; m_fail = 1'b0; m_prev = 1'b0;
         m_t = 0; m_faddr = '0; m_fsynd = '0;
      end else begin
         bit edge_seen;
         edge_seen = start && !m_prev;
         m_prev    = start;
         if (m_active) begin
            m_t++;
            if (m_t >= 2 && m_t - 2 < NACC && rd_bad[m_t-2] && !m_fail) begin
               m_fail  = 1'b1;
               m_faddr = acc_addr[m_t-2];
               m_fsynd = rd_synd[m_t-2];
            end
            if (m_t == NACC + 1) begin
               m_active = 1'b0;
               m_done   = 1'b1;
            end
         end else if (edge_seen) begin
            m_active = 1'b1; m_t = 0; m_done = 1'b0; m_fail = 1'b0;
            m_faddr = '0; m_fsynd = '0;
         end
      end
   endtask

   always @(posedge clk) model_step();

   always @(negedge clk) begin
      if (chk_en) begin
         bit e_ce;
         e_ce = m_active && (m_t < NACC);
         check("busy", 32'(busy), 32'(m_active));
         check("done", 32'(done), 32'(m_done));
         check("fail", 32'(fail), 32'(m_fail));
         check("mem_ce", 32'(ce), 32'(e_ce));
         if (e_ce) begin
            check("mem_we", 32'(we), 32'(acc_we[m_t]));
            check("mem_addr", 32'(addr), 32'(acc_addr[m_t]));
            if (acc_we[m_t]) check("mem_wdata", 32'(wdata), 32'(acc_data[m_t]));
         end
`ifdef BIST_DIAG_EN
         check("fail_addr", 32'(fail_addr), 32'(m_faddr));
         check("fail_synd", 32'(fail_synd), 32'(m_fsynd));
`endif
      end
   end

   // Directed run: log outputs per cycle after the start edge until DONE is seen
   int                ce_cnt, done_cyc;
   bit                log_ce [401], log_we [401], log_busy [401], log_done [401], log_fail [401];
   logic [ADDR_W-1:0] log_addr [401];

   task automatic run_directed(input int hold);
      start = 1'b0;
      @(negedge clk);
      start    = 1'b1;
      ce_cnt   = 0;
      done_cyc = -1;
      for (int c = 1; c <= 400 && done_cyc < 0; c++) begin
         @(negedge clk);
         log_ce[c] = ce; log_we[c] = we; log_addr[c] = addr;
         log_busy[c] = busy; log_done[c] = done; log_fail[c] = fail;
         if (ce) ce_cnt++;
         if (done) done_cyc = c;
         if (c >= hold) start = 1'b0;
      end
   endtask

   task automatic wait_idle();
      for (int w = 0; w < 400 && m_active; w++) @(negedge clk);
      check("idle_reached", 32'(busy), 32'd0);
   endtask

   initial begin
      bit ce_seen;
      build_tables();
      clear_faults();
      set_faults();
      for (int a = 0; a < N; a++) mem[a] = '0;

      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_ce", 32'(ce), 32'd0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Clean memory: 160 access cycles, DONE at +162, element order and boundaries
      run_directed(1);
      check("clean_ce_cycles", 32'(ce_cnt), 32'd160);
      check("clean_done_cycle", 32'(done_cyc), 32'd162);
      check("clean_fail", 32'(fail), 32'd0);
      check("first_we", 32'(log_we[1]), 32'd1);
      check("first_addr", 32'(log_addr[1]), 32'd0);
      check("m2_last_w_addr", 32'(log_addr[80]), 32'd15);
      check("m2_last_w_we", 32'(log_we[80]), 32'd1);
      check("m3_first_r_addr", 32'(log_addr[81]), 32'd15);
      check("m3_first_r_we", 32'(log_we[81]), 32'd0);
      check("m3_last_w_addr", 32'(log_addr[112]), 32'd0);
      check("m4_first_r_addr", 32'(log_addr[113]), 32'd15);
      check("drain_ce", 32'(log_ce[161]), 32'd0);
      check("drain_busy", 32'(log_busy[161]), 32'd1);

      // Stuck-at-0 on bit 3 of addr 5, START held high through FIN
      sa0[5] = 8'h08;
      set_faults();
      run_directed(1000);
      check("sa0_done_cycle", 32'(done_cyc), 32'd162);
      check("sa0_fail", 32'(fail), 32'd1);
`ifdef BIST_DIAG_EN
      check("sa0_fail_addr", 32'(fail_addr), 32'd5);
      check("sa0_fail_synd", 32'(fail_synd), 32'h08);
`endif
      ce_seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         ce_seen |= ce;
      end
      check("hold_no_rerun", 32'(ce_seen), 32'd0);
      check("hold_done", 32'(done), 32'd1);

      // Rerun on clean memory clears FAIL/DONE on entry to M0
      clear_faults();
      set_faults();
      check("pre_rerun_fail", 32'(fail), 32'd1);
      run_directed(1);
      check("rerun_fail_cleared", 32'(log_fail[1]), 32'd0);
      check("rerun_done_cleared", 32'(log_done[1]), 32'd0);
      check("rerun_done_cycle", 32'(done_cyc), 32'd162);
      check("rerun_fail", 32'(fail), 32'd0);

      // Reset during M3, then a fresh full run
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (89) @(negedge clk);
      check("m3_active_ce", 32'(ce), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_ce", 32'(ce), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_we", 32'(we), 32'd0);
      check("mid_rst_addr", 32'(addr), 32'd0);
      ce_seen = 1'b0;
      repeat (5) begin
         @(negedge clk);
         ce_seen |= ce;
      end
      check("post_rst_quiet", 32'(ce_seen), 32'd0);
      run_directed(1);
      check("post_rst_ce_cycles", 32'(ce_cnt), 32'd160);
      check("post_rst_done_cycle", 32'(done_cyc), 32'd162);

      // Randomised phase: random faults, START toggling, occasional resets
      for (int iter = 0; iter < 25; iter++) begin
         int ncyc;
         wait_idle();
         clear_faults();
         for (int f = $urandom_range(0, 2); f > 0; f--) begin
            int a = $urandom_range(0, N - 1);
            logic [DATA_W-1:0] m = DATA_W'(1) << $urandom_range(0, DATA_W - 1);
            if ($urandom_range(0, 1) == 0) sa0[a] |= m;
            else                           sa1[a] |= m;
         end
         set_faults();
         ncyc = $urandom_range(150, 450);
         for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 9) == 0) start = ~start;
         end
         @(negedge clk);
         rst = 1'b0;
      end
      wait_idle();
      repeat (2) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bistprj_mbist_ctrl.md
# bistprj_mbist_ctrl

March C- memory BIST controller for the bistprj BIST path. It is started and observed through JTAG TDR bits that the gasket routes to it. The block sequences a single-port synchronous SRAM through the six March C- elements and compares read data against the expected background. It reports busy, done and a sticky fail flag back to the TDRs.

## Interface
Parameters:
- ADDR_W, 4: memory address width; N = 2^ADDR_W words.
- DATA_W, 8: memory data width.

Ports:
- MAS_CLK  in  1  sole clock; all logic on its rising edge.
- MAS_RST  in  1  synchronous, active-high reset.
- BIST_START  in  1  level from TDR; a rising edge (sampled 1, previous sample 0) starts a run.
- BIST_BUSY  out  1  high while a run is in progress.
- BIST_DONE  out  1  high after run completion; held until next start edge or reset.
- BIST_FAIL  out  1  sticky; set on any read mismatch in the current run.
- BIST_FAIL_ADDR  out  ADDR_W  address of first mismatch (only with BIST_DIAG_EN).
- BIST_FAIL_SYND  out  DATA_W  read data XOR expected, first mismatch (only with BIST_DIAG_EN).
- MEM_CE  out  1  memory access strobe.
- MEM_WE  out  1  1 = write, 0 = read; valid when MEM_CE=1.
- MEM_ADDR  out  ADDR_W  access address.
- MEM_WDATA  out  DATA_W  write data: all-0 or all-1 background.
- MEM_RDATA  in  DATA_W  read data, valid exactly one cycle after the read access.

## Operation
- States: IDLE, M0, M1, M2, M3, M4, M5, DRAIN, FIN.
- IDLE → M0 on a start edge; FIN → M0 on a start edge. Start edges are ignored in any other state.
- Entering M0 clears BIST_DONE, BIST_FAIL and the diag registers.
- Elements (u = addr 0→N-1, d = addr N-1→0):
  - M0: u(w0).
  - M1: u(r0,w1).
  - M2: u(r1,w0).
  - M3: d(r0,w1).
  - M4: d(r1,w0).
  - M5: u(r0).
- M1–M4 take two cycles per address: read, then write to the same address. A phase bit selects the operation.
- Compare pipeline:
  - Every read registers its expected value and address.
  - The compare happens in the next cycle against MEM_RDATA.
  - A mismatch sets BIST_FAIL. The first mismatch of a run also captures address and syndrome; later mismatches do not overwrite them.
- M5 issues one read per cycle. DRAIN exists only to compare the final M5 read and issues no access.
- After DRAIN the block enters FIN: BUSY=0, DONE=1.
- Deasserting BIST_START mid-run has no effect; the run completes.
- Element transition: on the last address of an element, the next cycle starts the next element at its start address. There are no idle cycles between elements.

## Timing
- Reset values: all outputs 0, state IDLE, start-sample register 0.
- MAS_RST mid-run returns the block to IDLE at that edge. MEM_CE=0 from the following cycle, and the pending compare is discarded.
- All outputs are registered.
- Start edge sampled at edge k:
  - First access (M0, addr 0, WE=1, WDATA=0) is driven in cycle k+1.
  - BUSY=1 from cycle k+1.
  - Accesses occupy 10N consecutive cycles, with MEM_CE=1 continuously.
  - DRAIN follows with MEM_CE=0.
  - DONE=1 and BUSY=0 in cycle k+10N+2.
- For ADDR_W=4: 160 access cycles, and DONE rises 162 cycles after the start edge.
- A mismatch on the read issued in cycle c sets BIST_FAIL in cycle c+2, one cycle after the compare.
- BIST_START held high across FIN does not start a rerun; it must drop and rise again.

## Configuration
- BIST_DIAG_EN defined:
  - BIST_FAIL_ADDR and BIST_FAIL_SYND ports and their capture registers exist.
  - First-mismatch values are held until the next start edge or reset.
- BIST_DIAG_EN undefined:
  - Those ports and registers are absent.
  - Only BIST_FAIL reports failure.
  - Sequencing and timing are identical.

## Test plan
- Clean SRAM model, ADDR_W=4:
  - One start pulse gives exactly 160 MEM_CE cycles, in order M0 w0 ×16, then M1–M4 r/w pairs, then M5 r0 ×16.
  - DONE=1 at start+162, FAIL=0.
- Stuck-at-0 on bit 3 of addr 5: FAIL=1, FAIL_ADDR=5, FAIL_SYND=8'h08 (first detected by M2 r1). The run still completes with DONE=1.
- Address order check: M3 and M4 accesses go 15→0, and the M3 first read is at addr 15 the cycle after the last M2 write at addr 15.
- MAS_RST asserted during M3:
  - Next cycle all outputs are 0 and MEM_CE stays 0.
  - A fresh start edge reruns the full 160-cycle sequence.
- BIST_START held high through FIN: no new access, and DONE stays 1.
- After a failing run, toggling START clears FAIL and DONE at the start of M0. A clean memory then ends with FAIL=0.
